cache_mem_arbiter: RTL and testbench

- Shares the single memory-side generic bus between three requesters: the D$ miss/writeback port, the I$ fill port and the page-walker PTE port.
- Sits between the per-hart cache complex and the bus controller.
- Grants one requester at a time and holds the grant until the memory side completes the transaction, so read data, busy and writes never interleave across requesters.

---
 rtl/cache_mem_arbiter.sv | 116 +++++++++++
 tb/tb_cache_mem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory-side bus between the page walker, D$ and I$.
// Ports:
//   CLK, nRST                              clock, synchronous active-low reset
//   pw_* / d_* / i_*  (addr, wdata, byte_en, ren, wen)   requester inputs (I$ read only)
//   pw_rdata/pw_busy, d_rdata/d_busy, i_rdata/i_busy      requester responses
//   mem_addr/mem_wdata/mem_byte_en/mem_ren/mem_wen        memory request
//   mem_rdata/mem_busy                                    memory response
//   grant                                  current owner: 0 none, 1 PW, 2 D$, 3 I$
// Build option: CACHE_ARB_RR_EN selects round-robin between D$ and I$
// (default: fixed priority PW > D$ > I$).
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [ADDR_W-1:0]   pw_addr,
    input  logic [DATA_W-1:0]   pw_wdata,
    input  logic [DATA_W/8-1:0] pw_byte_en,
    input  logic                pw_ren,
    input  logic                pw_wen,
    output logic [DATA_W-1:0]   pw_rdata,
    output logic                pw_busy,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_byte_en,
    input  logic                d_ren,
    input  logic                d_wen,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_busy,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_ren,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_busy,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_byte_en,
    output logic                mem_ren,
    output logic                mem_wen,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_busy,
    output logic [1:0]          grant
);
    typedef enum logic {IDLE, OWN} state_e;
    localparam logic [1:0] G_NONE = 2'd0, G_PW = 2'd1, G_D = 2'd2, G_I = 2'd3;
    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] winner;
    logic       pw_req, d_req, i_req, sel_pw, sel_d, sel_i, own_req;
    assign pw_req = pw_ren | pw_wen;
    assign d_req  = d_ren | d_wen;
    assign i_req  = i_ren;
`ifdef CACHE_ARB_RR_EN
    // last_i_q: 1 when I$ was the most recent D$/I$ grant, so D$ wins the next tie
    logic last_i_q, last_i_d;
    assign winner = pw_req ? G_PW :
                    (d_req && i_req) ? (last_i_q ? G_D : G_I) :
                    d_req ? G_D : i_req ? G_I : G_NONE;
    always_comb begin
        last_i_d = last_i_q;
        if (state_q == IDLE && winner == G_D) last_i_d = 1'b0;
        if (state_q == IDLE && winner == G_I) last_i_d = 1'b1;
    end
    always_ff @(posedge CLK) begin
        if (!nRST) last_i_q <= 1'b1;
        else       last_i_q <= last_i_d;
    end
`else
    assign winner = pw_req ? G_PW : d_req ? G_D : i_req ? G_I : G_NONE;
`endif
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (state_q == IDLE && winner != G_NONE) begin
            state_d = OWN;
            owner_d = winner;
        end else if (state_q == OWN && !mem_busy) begin
            state_d = IDLE;
            owner_d = G_NONE;
        end
    end
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            owner_q <= G_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
    // owner_q is cleared whenever the FSM is idle, so it doubles as the grant
    assign sel_pw = state_q == OWN && owner_q == G_PW;
    assign sel_d  = state_q == OWN && owner_q == G_D;
    assign sel_i  = state_q == OWN && owner_q == G_I;
    assign grant  = state_q == OWN ? owner_q : G_NONE;
    assign own_req = (sel_pw & pw_req) | (sel_d & d_req) | (sel_i & i_req);
    assign mem_addr    = sel_pw ? pw_addr : sel_d ? d_addr : sel_i ? i_addr : '0;
    assign mem_wdata   = sel_pw ? pw_wdata : sel_d ? d_wdata : '0;
    assign mem_byte_en = sel_pw ? pw_byte_en : sel_d ? d_byte_en : '0;
    // a write wins over a simultaneous (illegal) read
    assign mem_wen = (sel_pw & pw_wen) | (sel_d & d_wen);
    assign mem_ren = (sel_pw & pw_ren & ~pw_wen) | (sel_d & d_ren & ~d_wen) | (sel_i & i_ren);
    assign pw_busy = sel_pw ? mem_busy : 1'b1;
    assign d_busy  = sel_d  ? mem_busy : 1'b1;
    assign i_busy  = sel_i  ? mem_busy : 1'b1;
    assign pw_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign i_rdata  = mem_rdata;
    always_ff @(posedge CLK) begin
        if (nRST) begin
            assert (!(pw_ren && pw_wen)) else $error("pw_ren and pw_wen both set");
            assert (!(d_ren && d_wen)) else $error("d_ren and d_wen both set");
            assert (state_q != OWN || own_req) else $error("owner dropped request before completion");
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: table-driven scoreboard bench for cache_mem_arbiter.
module tb_cache_mem_arbiter;
    localparam logic [31:0] K = 32'h5EAD_BEAF;
`ifdef CACHE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] pw_addr, pw_wdata, d_addr, d_wdata, i_addr;
    logic [3:0]  pw_byte_en, d_byte_en, mem_byte_en;
    logic        pw_ren, pw_wen, d_ren, d_wen, i_ren;
    logic [31:0] pw_rdata, d_rdata, i_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        pw_busy, d_busy, i_busy, mem_ren, mem_wen, mem_busy;
    logic [1:0]  grant;
    int          lat, cnt, n_vec, n_mis;
    logic [2:0]  pend, bsy;

    always #5 CLK = ~CLK;

    cache_mem_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .pw_addr(pw_addr), .pw_wdata(pw_wdata), .pw_byte_en(pw_byte_en),
        .pw_ren(pw_ren), .pw_wen(pw_wen), .pw_rdata(pw_rdata), .pw_busy(pw_busy),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_byte_en(d_byte_en),
        .d_ren(d_ren), .d_wen(d_wen), .d_rdata(d_rdata), .d_busy(d_busy),
        .i_addr(i_addr), .i_ren(i_ren), .i_rdata(i_rdata), .i_busy(i_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .grant(grant)
    );

    // memory model: busy for lat cycles of an active request, data is a fixed address hash
    always_ff @(posedge CLK) cnt <= (mem_ren || mem_wen) ? cnt + 1 : 0;
    assign mem_busy  = cnt < lat;
    assign mem_rdata = mem_addr ^ K;
    assign pend = {i_ren, d_ren | d_wen, pw_ren};
    assign bsy  = {i_busy, d_busy, pw_busy};

    typedef struct {
        logic pw, d, dw, i, rst;
        int lat;
        logic [31:0] pa, da, ia;
        logic [2:0][1:0] ord;
    } scn_t;
    typedef struct {
        logic [1:0] id;
        int cyc;
        logic [31:0] addr;
        logic wr;
    } exp_t;
    scn_t tbl[10];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic scn_t mk(input int k, input logic p, input logic dd, input logic w,
                                input logic ii, input logic r, input int l,
                                input logic [1:0] o0, input logic [1:0] o1, input logic [1:0] o2);
        scn_t s;
        s.pw = p; s.d = dd; s.dw = w; s.i = ii; s.rst = r; s.lat = l;
        s.pa = 32'h1000_0100 + 32'(k * 16);
        s.da = 32'h2000_0200 + 32'(k * 16);
        s.ia = 32'h8000_0040 + 32'(k * 16);
        s.ord = {o2, o1, o0};
        return s;
    endfunction

    function automatic logic [31:0] addr_of(input scn_t s, input logic [1:0] id);
        return id == 2'd1 ? s.pa : id == 2'd2 ? s.da : s.ia;
    endfunction

    function automatic logic [31:0] rdata_of(input int r);
        return r == 1 ? pw_rdata : r == 2 ? d_rdata : i_rdata;
    endfunction

    task automatic run(input int k, input scn_t s);
        int c;
        bit gap;
        logic [2:0] drop;
        exp_t e;
        if (s.rst) begin
            @(posedge CLK); #1 nRST = 1'b0;
            @(posedge CLK); #1 nRST = 1'b1;
        end
        @(posedge CLK); #1;
        lat = s.lat;
        pw_addr = s.pa; d_addr = s.da; i_addr = s.ia;
        d_wdata = s.dw ? 32'h1234_5678 : 32'h0;
        pw_ren = s.pw; d_ren = s.d & ~s.dw; d_wen = s.d & s.dw; i_ren = s.i;
        for (int j = 0; j < 3; j++)
            if (s.ord[j] != 2'd0)
                sb.push_back('{s.ord[j], 1 + s.lat + j * (s.lat + 2), addr_of(s, s.ord[j]),
                               s.ord[j] == 2'd2 && s.dw});
        c = 0;
        gap = 1'b0;
        while ((sb.size() > 0 || gap) && c < 60) begin
            @(negedge CLK);
            drop = 3'b000;
            if (gap) chk($sformatf("v%0d idle_gap grant", k), 32'(grant), 32'd0);
            gap = 1'b0;
            for (int r = 1; r <= 3; r++) begin
                if (pend[r-1] && !bsy[r-1]) begin
                    drop[r-1] = 1'b1;
                    gap = 1'b1;
                    if (sb.size() == 0) begin
                        n_vec++; n_mis++;
                        $display("FAIL v%0d unexpected completion: got requester %0d, expected none", k, r);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("v%0d owner", k), 32'(r), 32'(e.id));
                        chk($sformatf("v%0d cycle", k), 32'(c), 32'(e.cyc));
                        chk($sformatf("v%0d grant", k), 32'(grant), 32'(e.id));
                        chk($sformatf("v%0d mem_addr", k), mem_addr, e.addr);
                        chk($sformatf("v%0d busy_vec", k), 32'(bsy), 32'(3'b111 & ~(3'b001 << (r - 1))));
                        if (e.wr) begin
                            chk($sformatf("v%0d mem_wen", k), 32'(mem_wen), 32'd1);
                            chk($sformatf("v%0d mem_ren", k), 32'(mem_ren), 32'd0);
                            chk($sformatf("v%0d mem_wdata", k), mem_wdata, 32'h1234_5678);
                            chk($sformatf("v%0d mem_byte_en", k), 32'(mem_byte_en), 32'hF);
                        end else begin
                            chk($sformatf("v%0d mem_ren", k), 32'(mem_ren), 32'd1);
                            chk($sformatf("v%0d rdata", k), rdata_of(r), e.addr ^ K);
                        end
                    end
                end
            end
            @(posedge CLK); #1;
            if (drop[0]) pw_ren = 1'b0;
            if (drop[1]) begin d_ren = 1'b0; d_wen = 1'b0; end
            if (drop[2]) i_ren = 1'b0;
            c++;
        end
        if (sb.size() > 0) begin
            n_vec++; n_mis++;
            $display("FAIL v%0d timeout: got %0d outstanding, expected 0", k, sb.size());
            sb.delete();
        end
        pw_ren = 1'b0; d_ren = 1'b0; d_wen = 1'b0; i_ren = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_mis = 0; lat = 0; nRST = 1'b0;
        pw_addr = '0; pw_wdata = 32'hAAAA_0000; pw_byte_en = 4'hF; pw_ren = 0; pw_wen = 0;
        d_addr = '0; d_wdata = '0; d_byte_en = 4'hF; d_ren = 0; d_wen = 0;
        i_addr = '0; i_ren = 0;
        tbl[0] = mk(0, 0, 0, 0, 1, 0, 3, 2'd3, 2'd0, 2'd0);
        tbl[1] = mk(1, 0, 1, 0, 1, 0, 0, 2'd2, 2'd3, 2'd0);
        tbl[2] = mk(2, 0, 1, 0, 1, 0, 0, 2'd2, 2'd3, 2'd0);
        tbl[3] = mk(3, 0, 1, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0);
        tbl[4] = mk(4, 0, 1, 0, 1, 0, 0, RR ? 2'd3 : 2'd2, RR ? 2'd2 : 2'd3, 2'd0);
        tbl[5] = mk(5, 1, 1, 0, 1, 1, 0, 2'd1, 2'd2, 2'd3);
        tbl[6] = mk(6, 0, 1, 1, 1, 0, 2, 2'd2, 2'd3, 2'd0);
        tbl[7] = mk(7, 1, 0, 0, 1, 0, 1, 2'd1, 2'd3, 2'd0);
        tbl[8] = mk(8, 1, 1, 0, 0, 0, 2, 2'd1, 2'd2, 2'd0);
        tbl[9] = mk(9, 0, 1, 0, 1, 0, 0, RR ? 2'd3 : 2'd2, RR ? 2'd2 : 2'd3, 2'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst grant", 32'(grant), 32'd0);
        chk("rst mem_ren", 32'(mem_ren), 32'd0);
        chk("rst mem_wen", 32'(mem_wen), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst mem_byte_en", 32'(mem_byte_en), 32'd0);
        chk("rst busy_vec", 32'(bsy), 32'h7);
        chk("rst d_rdata", d_rdata, K);
        chk("rst i_rdata", i_rdata, K);
        chk("rst pw_rdata", pw_rdata, K);
        nRST = 1'b1;
        for (int k = 0; k < 10; k++) run(k, tbl[k]);
        // reset in the middle of a long I$ transaction, then a fresh D$ request
        @(posedge CLK); #1;
        lat = 10; i_addr = 32'h8000_0100; i_ren = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("mid grant before reset", 32'(grant), 32'd3);
        nRST = 1'b0; i_ren = 1'b0;
        @(negedge CLK);
        chk("mid rst grant", 32'(grant), 32'd0);
        chk("mid rst mem_ren", 32'(mem_ren), 32'd0);
        chk("mid rst mem_addr", mem_addr, 32'd0);
        chk("mid rst busy_vec", 32'(bsy), 32'h7);
        nRST = 1'b1; lat = 0; d_addr = 32'h2000_0400; d_ren = 1'b1;
        @(negedge CLK);
        chk("post rst grant", 32'(grant), 32'd2);
        chk("post rst d_busy", 32'(d_busy), 32'd0);
        chk("post rst d_rdata", d_rdata, 32'h2000_0400 ^ K);
        @(posedge CLK); #1 d_ren = 1'b0;
        @(negedge CLK);
        chk("post rst idle grant", 32'(grant), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
